// File: rtl/avmm_pkg.sv
// avmm_pkg: shared types, bus widths and the active-low byte-lane merge helper.
package avmm_pkg;
  localparam int AVM_DW = 32;
  localparam int AVM_AW = 25;
  typedef enum logic [1:0] {S_INIT, S_RUN, S_REFRESH} state_t;
  function automatic logic [AVM_DW-1:0] be_merge(input logic [AVM_DW-1:0] old,
                                                 input logic [AVM_DW-1:0] wdata,
                                                 input logic [3:0] be_n);
    logic [AVM_DW-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (!be_n[i]) r[8*i +: 8] = wdata[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/avmm_rd_pipe.sv
// avmm_rd_pipe: fixed-latency read return pipeline; o_data holds between valid pulses.
module avmm_rd_pipe import avmm_pkg::*; #(
  parameter int RD_LAT = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_vld,
  input  logic [AVM_DW-1:0] i_data,
  output logic              o_vld,
  output logic [AVM_DW-1:0] o_data
);
  logic [RD_LAT-1:0] vld_q;
  logic [AVM_DW-1:0] data_q [RD_LAT];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      vld_q  <= '0;
      o_vld  <= 1'b0;
      o_data <= '0;
      for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
    end else begin
      vld_q[0]  <= i_vld;
      data_q[0] <= i_data;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
      o_vld <= vld_q[RD_LAT-1];
      if (vld_q[RD_LAT-1]) o_data <= data_q[RD_LAT-1];
    end
endmodule

// File: rtl/avmm_sdram_responder.sv
// avmm_sdram_responder: Avalon-MM SDRAM-controller stand-in over on-chip RAM.
// Define AVS_RANDOM_STALL_EN to add LFSR-driven pseudo-random waitrequest stalls.
module avmm_sdram_responder import avmm_pkg::*; #(
  parameter int MEM_AW         = 10,
  parameter int RD_LAT         = 3,
  parameter int MAX_PEND       = 2,
  parameter int INIT_CYCLES    = 16,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [AVM_AW-1:0] avs_address,
  input  logic [3:0]        avs_byteenable_n,
  input  logic              avs_chipselect,
  input  logic [AVM_DW-1:0] avs_writedata,
  input  logic              avs_read_n,
  input  logic              avs_write_n,
  output logic [AVM_DW-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic [3:0]        o_rd_pending
);
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, ref_q, ref_d;
  logic [3:0] pend_q, pend_d;
  logic refresh_due, acc, wr_acc, rd_acc;
  logic [MEM_AW-1:0] addr;
  logic [AVM_DW-1:0] mem [2**MEM_AW];
  logic unused_addr_hi;
  assign unused_addr_hi = ^avs_address[AVM_AW-1:MEM_AW];
  assign addr = avs_address[MEM_AW-1:0];
  assign refresh_due = state_q == S_RUN && ref_q == 16'(REFRESH_PERIOD-1);
`ifdef AVS_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) lfsr_q <= 16'hACE1;
    else lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign avs_waitrequest = state_q != S_RUN || refresh_due || pend_q >= 4'(MAX_PEND) || lfsr_q[1:0] == 2'b00;
`else
  assign avs_waitrequest = state_q != S_RUN || refresh_due || pend_q >= 4'(MAX_PEND);
`endif
  // A simultaneous read+write strobe is a single write accept.
  assign acc    = avs_chipselect && (!avs_read_n || !avs_write_n) && !avs_waitrequest;
  assign wr_acc = acc && !avs_write_n;
  assign rd_acc = acc && avs_write_n;
  assign o_rd_pending = pend_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    unique case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(INIT_CYCLES-1)) begin
          state_d = S_RUN;
          ref_d   = '0;
        end
      end
      S_RUN: begin
        ref_d = ref_q + 16'd1;
        if (refresh_due) begin
          state_d = S_REFRESH;
          cnt_d   = '0;
        end
      end
      S_REFRESH: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(REFRESH_CYCLES-1)) begin
          state_d = S_RUN;
          ref_d   = '0;
        end
      end
      default: state_d = S_INIT;
    endcase
    pend_d = pend_q + {3'b0, rd_acc} - {3'b0, avs_readdatavalid};
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ref_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      pend_q  <= pend_d;
    end
  always_ff @(posedge i_clk)
    if (wr_acc) mem[addr] <= be_merge(mem[addr], avs_writedata, avs_byteenable_n);
  avmm_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_vld  (rd_acc),
    .i_data (mem[addr]),
    .o_vld  (avs_readdatavalid),
    .o_data (avs_readdata)
  );
endmodule
